// File: rtl/apple1_pia_pkg.sv
// Apple-1 PIA register map and keyboard buffer sizing shared by the PIA block.
// Pure declarations: no latency, no flow control.
package apple1_pia_pkg;

  localparam logic [1:0] PIA_KBD   = 2'd0;
  localparam logic [1:0] PIA_KBDCR = 2'd1;
  localparam logic [1:0] PIA_DSP   = 2'd2;
  localparam logic [1:0] PIA_DSPCR = 2'd3;

  localparam int PIA_KBD_DEPTH_DEF = 4;

endpackage

// File: rtl/apple1_kbd_fifo.sv
// Keyboard key FIFO: head visible combinationally, push/pop take effect on the clk14 edge.
// Push while full is ignored unless a pop happens on the same edge; pop while empty is ignored.
module apple1_kbd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 7
) (
  input  logic             clk14,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_dat,
  output logic [WIDTH-1:0] rd_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_dat  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk14) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk14) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_dat;
  end

endmodule

// File: rtl/apple1_pia.sv
// Apple-1 PIA (KBD/KBDCR/DSP/DSPCR): bus effects on cpu_clken edges, dout combinational, keys/display 1-cycle latency.
// Display held until dsp_ready; APPLE1_PIA_KBD_FIFO_EN buffers keys in a FIFO (drop + sticky ovr when full).
module apple1_pia
  import apple1_pia_pkg::*;
#(
  parameter int KBD_DEPTH = PIA_KBD_DEPTH_DEF
) (
  input  logic       clk14,
  input  logic       rst,
  input  logic       cpu_clken,
  input  logic       cs,
  input  logic       rw,
  input  logic [1:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic [6:0] kbd_data,
  input  logic       kbd_strobe,
  output logic [6:0] dsp_data,
  output logic       dsp_valid,
  input  logic       dsp_ready
);

  logic       bus_acc;
  logic       rd_kbd;
  logic       rd_kbdcr;
  logic       wr_kbdcr;
  logic       wr_dsp;
  logic       wr_dspcr;
  logic       dsp_xfer;

  logic [6:0] key_dat;
  logic       key_avail;
  logic       key_ovr;
  logic [5:0] kbdcr;
  logic [6:0] dspcr;
  logic [6:0] dsp_dat_q;
  logic       dsp_busy;
  logic       unused_bits;

  assign bus_acc  = cs & cpu_clken;
  assign rd_kbd   = bus_acc &  rw & (addr == PIA_KBD);
  assign rd_kbdcr = bus_acc &  rw & (addr == PIA_KBDCR);
  assign wr_kbdcr = bus_acc & ~rw & (addr == PIA_KBDCR);
  assign wr_dsp   = bus_acc & ~rw & (addr == PIA_DSP);
  assign wr_dspcr = bus_acc & ~rw & (addr == PIA_DSPCR);
  assign dsp_xfer = dsp_busy & dsp_ready;

  // din[7] has no storage in any register.
  assign unused_bits = din[7];

`ifdef APPLE1_PIA_KBD_FIFO_EN
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_pop;
  logic       fifo_push;
  logic [6:0] fifo_head;
  logic       ovr_q;

  assign fifo_pop  = rd_kbd & ~fifo_empty;
  assign fifo_push = kbd_strobe & (~fifo_full | fifo_pop);

  apple1_kbd_fifo #(
    .DEPTH (KBD_DEPTH),
    .WIDTH (7)
  ) u_kbd_fifo (
    .clk14  (clk14),
    .rst    (rst),
    .push   (fifo_push),
    .pop    (fifo_pop),
    .wr_dat (kbd_data),
    .rd_dat (fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // An empty buffer reads as key 0 so KBD shows $80 like the reset state.
  assign key_avail = ~fifo_empty;
  assign key_dat   = fifo_empty ? 7'd0 : fifo_head;
  assign key_ovr   = ovr_q;

  always_ff @(posedge clk14) begin
    if (rst) begin
      ovr_q <= 1'b0;
    end else if (kbd_strobe & fifo_full & ~fifo_pop) begin
      ovr_q <= 1'b1;
    end else if (rd_kbdcr) begin
      ovr_q <= 1'b0;
    end
  end
`else
  logic [6:0] key_q;
  logic       avail_q;
  logic       unused_depth;

  assign unused_depth = (KBD_DEPTH != 0);
  assign key_dat      = key_q;
  assign key_avail    = avail_q;
  assign key_ovr      = 1'b0;

  // A strobe wins over a same-edge KBD read so the new key is never lost.
  always_ff @(posedge clk14) begin
    if (rst) begin
      key_q   <= '0;
      avail_q <= 1'b0;
    end else if (kbd_strobe) begin
      key_q   <= kbd_data;
      avail_q <= 1'b1;
    end else if (rd_kbd) begin
      avail_q <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk14) begin
    if (rst) begin
      kbdcr <= '0;
      dspcr <= '0;
    end else begin
      if (wr_kbdcr) kbdcr <= din[5:0];
      if (wr_dspcr) dspcr <= din[6:0];
    end
  end

  // A CPU write outranks the terminal accept: the old character leaves, the new one stays pending.
  always_ff @(posedge clk14) begin
    if (rst) begin
      dsp_dat_q <= '0;
      dsp_busy  <= 1'b0;
    end else if (wr_dsp) begin
      dsp_dat_q <= din[6:0];
      dsp_busy  <= 1'b1;
    end else if (dsp_xfer) begin
      dsp_busy  <= 1'b0;
    end
  end

  assign dsp_data  = dsp_dat_q;
  assign dsp_valid = dsp_busy;

  always_comb begin
    dout = 8'h00;
    case (addr)
      PIA_KBD:   dout = {1'b1, key_dat};
      PIA_KBDCR: dout = {key_avail, key_ovr, kbdcr};
      PIA_DSP:   dout = {dsp_busy, dsp_dat_q};
      PIA_DSPCR: dout = {1'b0, dspcr};
      default:   dout = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_apple1_pia.sv
// Directed-vector bench for apple1_pia; expected values are hand-computed constants.
// Covers both builds of APPLE1_PIA_KBD_FIFO_EN.
module tb_apple1_pia;

  logic       clk14 = 1'b0;
  logic       rst = 1'b0;
  logic       cpu_clken = 1'b0;
  logic       cs = 1'b0;
  logic       rw = 1'b1;
  logic [1:0] addr = 2'd0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic [6:0] kbd_data = 7'h00;
  logic       kbd_strobe = 1'b0;
  logic [6:0] dsp_data;
  logic       dsp_valid;
  logic       dsp_ready = 1'b0;

  int n_vec = 0;
  int n_bad = 0;

  apple1_pia #(.KBD_DEPTH(4)) dut (
    .clk14      (clk14),
    .rst        (rst),
    .cpu_clken  (cpu_clken),
    .cs         (cs),
    .rw         (rw),
    .addr       (addr),
    .din        (din),
    .dout       (dout),
    .kbd_data   (kbd_data),
    .kbd_strobe (kbd_strobe),
    .dsp_data   (dsp_data),
    .dsp_valid  (dsp_valid),
    .dsp_ready  (dsp_ready)
  );

  always #5 clk14 = ~clk14;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h, expected %02h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk14);
    #1;
  endtask

  task automatic peek(input logic [1:0] a, output logic [7:0] d);
    cs = 1'b0;
    addr = a;
    @(negedge clk14);
    d = dout;
  endtask

  task automatic bus_rd(input logic [1:0] a, input logic en, output logic [7:0] d);
    cs = 1'b1; rw = 1'b1; addr = a; cpu_clken = en;
    @(negedge clk14);
    d = dout;
    tick();
    cs = 1'b0; cpu_clken = 1'b0;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [7:0] v, input logic en);
    cs = 1'b1; rw = 1'b0; addr = a; din = v; cpu_clken = en;
    tick();
    cs = 1'b0; rw = 1'b1; cpu_clken = 1'b0;
  endtask

  task automatic strobe(input logic [6:0] k);
    kbd_data = k;
    kbd_strobe = 1'b1;
    tick();
    kbd_strobe = 1'b0;
  endtask

  logic [7:0] v;

  initial begin
    // Reset
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_dsp_valid", {7'd0, dsp_valid}, 8'h00);
    chk("rst_dsp_data", {1'b0, dsp_data}, 8'h00);
    peek(2'd0, v); chk("rst_kbd", v, 8'h80);
    peek(2'd1, v); chk("rst_kbdcr", v, 8'h00);
    peek(2'd2, v); chk("rst_dsp", v, 8'h00);
    peek(2'd3, v); chk("rst_dspcr", v, 8'h00);

    // Single key, read gated by cpu_clken
    tick();
    strobe(7'h41);
    peek(2'd1, v); chk("key_avail", v, 8'h80);
    peek(2'd0, v); chk("key_kbd", v, 8'hC1);
    bus_rd(2'd0, 1'b0, v);
    peek(2'd1, v); chk("key_noclken", v, 8'h80);
    bus_rd(2'd0, 1'b1, v); chk("key_rd_val", v, 8'hC1);
    peek(2'd1, v); chk("key_consumed", v, 8'h00);

    // Control registers
    bus_wr(2'd1, 8'hFF, 1'b1);
    peek(2'd1, v); chk("kbdcr_wr", v, 8'h3F);
    bus_wr(2'd3, 8'hFF, 1'b1);
    peek(2'd3, v); chk("dspcr_wr", v, 8'h7F);
    bus_wr(2'd1, 8'h15, 1'b0);
    peek(2'd1, v); chk("kbdcr_noclken", v, 8'h3F);
    bus_wr(2'd0, 8'h55, 1'b1);
    peek(2'd1, v); chk("kbd_wr_ignored", v, 8'h3F);
    bus_wr(2'd1, 8'h00, 1'b1);
    bus_wr(2'd3, 8'h2A, 1'b1);
    peek(2'd3, v); chk("dspcr_wr2", v, 8'h2A);

    // Display handshake
    bus_wr(2'd2, 8'h8D, 1'b0);
    chk("dsp_noclken", {7'd0, dsp_valid}, 8'h00);
    bus_wr(2'd2, 8'h8D, 1'b1);
    chk("dsp_valid_set", {7'd0, dsp_valid}, 8'h01);
    chk("dsp_data_set", {1'b0, dsp_data}, 8'h0D);
    peek(2'd2, v); chk("dsp_rd_busy", v, 8'h8D);
    repeat (20) tick();
    chk("dsp_hold_valid", {7'd0, dsp_valid}, 8'h01);
    chk("dsp_hold_data", {1'b0, dsp_data}, 8'h0D);
    dsp_ready = 1'b1;
    tick();
    dsp_ready = 1'b0;
    chk("dsp_accept", {7'd0, dsp_valid}, 8'h00);
    peek(2'd2, v); chk("dsp_rd_idle", v, 8'h0D);

    // Overwrite while busy, then accept colliding with a new write
    bus_wr(2'd2, 8'h33, 1'b1);
    bus_wr(2'd2, 8'h41, 1'b1);
    chk("dsp_overwrite", {1'b0, dsp_data}, 8'h41);
    dsp_ready = 1'b1;
    cs = 1'b1; rw = 1'b0; addr = 2'd2; din = 8'hC2; cpu_clken = 1'b1;
    @(negedge clk14);
    chk("coll_xfer_dat", {dsp_valid, dsp_data}, 8'hC1);
    tick();
    cs = 1'b0; rw = 1'b1; cpu_clken = 1'b0; dsp_ready = 1'b0;
    chk("coll_valid", {7'd0, dsp_valid}, 8'h01);
    chk("coll_data", {1'b0, dsp_data}, 8'h42);
    dsp_ready = 1'b1;
    tick();
    dsp_ready = 1'b0;
    chk("coll_drain", {7'd0, dsp_valid}, 8'h00);

    // Strobe and KBD read on the same edge
    strobe(7'h50);
    kbd_data = 7'h51; kbd_strobe = 1'b1;
    bus_rd(2'd0, 1'b1, v);
    kbd_strobe = 1'b0;
    chk("same_edge_rd", v, 8'hD0);
    peek(2'd1, v); chk("same_edge_avail", v, 8'h80);
    peek(2'd0, v); chk("same_edge_key", v, 8'hD1);
    bus_rd(2'd0, 1'b1, v);
    peek(2'd1, v); chk("same_edge_drain", v, 8'h00);

    // Five keys with no reads
    for (int i = 1; i <= 5; i++) begin
      strobe(7'h30 + 7'(i));
      tick();
    end
`ifdef APPLE1_PIA_KBD_FIFO_EN
    peek(2'd1, v); chk("ovf_kbdcr", v, 8'hC0);
    for (int i = 1; i <= 4; i++) begin
      bus_rd(2'd0, 1'b1, v);
      chk("ovf_kbd_pop", v, 8'hB0 + 8'(i));
    end
    peek(2'd1, v); chk("ovf_sticky", v, 8'h40);
    bus_rd(2'd1, 1'b1, v); chk("ovf_kbdcr_rd", v, 8'h40);
    peek(2'd1, v); chk("ovf_cleared", v, 8'h00);
`else
    peek(2'd1, v); chk("lw_kbdcr", v, 8'h80);
    bus_rd(2'd0, 1'b1, v); chk("lw_kbd", v, 8'hB5);
    peek(2'd1, v); chk("lw_after", v, 8'h00);
`endif

    // Reset in the middle of a pending character and a buffered key
    bus_wr(2'd2, 8'h55, 1'b1);
    strobe(7'h66);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", {7'd0, dsp_valid}, 8'h00);
    peek(2'd1, v); chk("mid_rst_kbdcr", v, 8'h00);
    peek(2'd2, v); chk("mid_rst_dsp", v, 8'h00);
    peek(2'd3, v); chk("mid_rst_dspcr", v, 8'h00);
    peek(2'd0, v); chk("mid_rst_kbd", v, 8'h80);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
